clip_record_play_ctrl: RTL and testbench

//   Parametrised record/playback sequencer for the clip audio path: NUM_CLIPS clip

---
 rtl/clip_record_play_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_clip_record_play_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_record_play_ctrl.sv
// ---------------------------------------------------------------------------
// clip_record_play_ctrl
//
// Record/playback sequencer for the clip audio path. The clip memory holds
// NUM_CLIPS slots of CLIP_SAMPLES samples each. Recording enables the
// deserialiser and writes one sample per sample_tick. Playback enables the
// serialiser and steps the read address once per sample_tick. Clip length
// is timed by counting sample_tick, so no external timer is needed. A
// per-slot valid bit records which slots hold a complete recording.
//
// Optional feature macro: CLIP_LOOP_EN
//   When defined, playback with loop=1 wraps to the start of the clip at the
//   final sample and pulses done on every wrap. When undefined, the loop input
//   is ignored and playback always stops after one pass.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset, returns to IDLE
//   record_req   in   level request: record into slot clip_sel
//   play_req     in   level request: play slot clip_sel
//   clip_sel     in   slot index, sampled only when a request is accepted
//   stop         in   abort the current record/playback
//   loop         in   repeat playback (CLIP_LOOP_EN builds only)
//   sample_tick  in   one-cycle strobe per audio sample period
//   mem_clip     out  slot index of the active (or last) operation
//   mem_addr     out  sample address within the slot
//   mem_we       out  memory write strobe
//   deseri_ena   out  high throughout RECORD
//   seri_ena     out  high throughout PLAY
//   busy         out  high in RECORD, PLAY or DONE
//   done         out  one-cycle pulse on normal completion (and loop wrap)
//   err          out  one-cycle pulse when a request is rejected
//   clip_valid   out  bit i set = slot i holds a complete recording
// ---------------------------------------------------------------------------
module clip_record_play_ctrl #(
  parameter int NUM_CLIPS    = 2,
  parameter int CLIP_SAMPLES = 16000,
  parameter int ADDR_W       = 14,
  localparam int CLIP_W      = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 record_req,
  input  logic                 play_req,
  input  logic [CLIP_W-1:0]    clip_sel,
  input  logic                 stop,
  input  logic                 loop,
  input  logic                 sample_tick,
  output logic [CLIP_W-1:0]    mem_clip,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic                 deseri_ena,
  output logic                 seri_ena,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NUM_CLIPS-1:0] clip_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLIP_SAMPLES - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      count_q, count_d;
  logic [CLIP_W-1:0]      clip_q, clip_d;
  logic [NUM_CLIPS-1:0]   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   loop_done_q, loop_done_d;
  logic                   sel_ok;
  logic                   at_last;

`ifndef CLIP_LOOP_EN
  // The loop input has no function in a non-looping build.
  logic unused_loop;
  assign unused_loop = loop;
`endif

  // Slot indices can exceed NUM_CLIPS-1 when NUM_CLIPS is not a power of two.
  assign sel_ok  = 32'(clip_sel) < 32'(NUM_CLIPS);
  assign at_last = (count_q == LAST_ADDR);

  // State and datapath registers; reset discards all recorded-slot knowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      clip_q      <= '0;
      valid_q     <= '0;
      err_q       <= 1'b0;
      loop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      clip_q      <= clip_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      loop_done_q <= loop_done_d;
    end
  end

  // Next-state logic. In IDLE, record_req outranks play_req. While active,
  // stop outranks a coincident tick so an aborted final sample never
  // completes the clip. The counter holds at the last address on completion
  // and after an abort, so mem_addr keeps its last value in IDLE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clip_d      = clip_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    loop_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (record_req || play_req) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else if (record_req) begin
            state_d           = RECORD;
            clip_d            = clip_sel;
            count_d           = '0;
            valid_d[clip_sel] = 1'b0;
          end else if (!valid_q[clip_sel]) begin
            err_d = 1'b1;
          end else begin
            state_d = PLAY;
            clip_d  = clip_sel;
            count_d = '0;
          end
        end
      end
      RECORD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          if (at_last) begin
            valid_d[clip_q] = 1'b1;
            state_d         = DONE;
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          if (at_last) begin
`ifdef CLIP_LOOP_EN
            if (loop) begin
              count_d     = '0;
              loop_done_d = 1'b1;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. The write strobe follows sample_tick directly so the
  // sample is written in the same cycle it arrives.
  always_comb begin
    mem_clip   = clip_q;
    mem_addr   = count_q;
    mem_we     = (state_q == RECORD) && sample_tick;
    deseri_ena = (state_q == RECORD);
    seri_ena   = (state_q == PLAY);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE) || loop_done_q;
    err        = err_q;
    clip_valid = valid_q;
  end

endmodule

// File: tb/tb_clip_record_play_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clip_record_play_ctrl
//
// Directed bench for clip_record_play_ctrl with 8-sample clips. A reference
// model tracks the operation in terms of "ticks consumed in this operation"
// and derives address, done and valid bits from that count; every cycle
// outside reset the DUT outputs are compared against it. Literal checks pin
// the model on the main scenarios (address sequences, pulse counts, valid
// bits).
// ---------------------------------------------------------------------------
module tb_clip_record_play_ctrl;

  localparam int NUM_CLIPS    = 2;
  localparam int CLIP_SAMPLES = 8;
  localparam int ADDR_W       = 3;
  localparam int CLIP_W       = 1;

`ifdef CLIP_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 record_req = 1'b0;
  logic                 play_req = 1'b0;
  logic [CLIP_W-1:0]    clip_sel = '0;
  logic                 stop = 1'b0;
  logic                 loop = 1'b0;
  logic                 sample_tick = 1'b0;
  logic [CLIP_W-1:0]    mem_clip;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_we;
  logic                 deseri_ena;
  logic                 seri_ena;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [NUM_CLIPS-1:0] clip_valid;

  int checks = 0;
  int errors = 0;

  clip_record_play_ctrl #(
    .NUM_CLIPS   (NUM_CLIPS),
    .CLIP_SAMPLES(CLIP_SAMPLES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .record_req (record_req),
    .play_req   (play_req),
    .clip_sel   (clip_sel),
    .stop       (stop),
    .loop       (loop),
    .sample_tick(sample_tick),
    .mem_clip   (mem_clip),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .deseri_ena (deseri_ena),
    .seri_ena   (seri_ena),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .clip_valid (clip_valid)
  );

  always #5 clock = ~clock;

  // Reference model. Activity: 0 none, 1 recording, 2 playing, 3 finishing.
  int          m_act = 0;
  int          m_ticks = 0;
  int          m_addr = 0;
  int          m_clip = 0;
  bit [1:0]    m_valid = 2'b00;
  bit          m_err = 1'b0;
  bit          m_wrap = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act   = 0;
      m_ticks = 0;
      m_addr  = 0;
      m_clip  = 0;
      m_valid = 2'b00;
      m_err   = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      m_err  = 1'b0;
      m_wrap = 1'b0;
      if (m_act == 3) begin
        m_act = 0;
      end else if (m_act == 0) begin
        if (record_req || play_req) begin
          if (int'(clip_sel) >= NUM_CLIPS) m_err = 1'b1;
          else if (record_req) begin
            m_act = 1; m_clip = int'(clip_sel); m_ticks = 0; m_addr = 0;
            m_valid[clip_sel] = 1'b0;
          end else if (!m_valid[clip_sel]) m_err = 1'b1;
          else begin
            m_act = 2; m_clip = int'(clip_sel); m_ticks = 0; m_addr = 0;
          end
        end
      end else if (stop) begin
        m_act = 0;
      end else if (sample_tick) begin
        m_ticks++;
        if (m_ticks % CLIP_SAMPLES != 0) begin
          m_addr = m_ticks % CLIP_SAMPLES;
        end else if (m_act == 2 && LOOP_BUILD && loop) begin
          m_addr = 0;
          m_wrap = 1'b1;
        end else begin
          if (m_act == 1) m_valid[m_clip] = 1'b1;
          m_addr = CLIP_SAMPLES - 1;
          m_act  = 3;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Observation logs used by the literal checks.
  int we_log[$];
  int play_log[$];
  int done_cnt = 0;
  int err_cnt = 0;

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("busy",       32'(busy),       32'(m_act != 0));
      checkOutput("deseri_ena", 32'(deseri_ena), 32'(m_act == 1));
      checkOutput("seri_ena",   32'(seri_ena),   32'(m_act == 2));
      checkOutput("mem_we",     32'(mem_we),     32'(m_act == 1 && sample_tick));
      checkOutput("mem_addr",   32'(mem_addr),   32'(m_addr));
      checkOutput("mem_clip",   32'(mem_clip),   32'(m_clip));
      checkOutput("done",       32'(done),       32'(m_act == 3 || m_wrap));
      checkOutput("err",        32'(err),        32'(m_err));
      checkOutput("clip_valid", 32'(clip_valid), 32'(m_valid));
      if (mem_we) we_log.push_back(int'(mem_addr));
      if (seri_ena && sample_tick) play_log.push_back(int'(mem_addr));
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  // Drive one cycle of inputs; returns 2 time units after the consuming edge.
  task automatic applyStimulus(input logic rec, input logic ply, input logic sel,
                               input logic stp, input logic lp, input logic tck);
    record_req  = rec;
    play_req    = ply;
    clip_sel    = sel;
    stop        = stp;
    loop        = lp;
    sample_tick = tck;
    @(posedge clock);
    #2;
  endtask

  task automatic clearLogs();
    we_log.delete();
    play_log.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  initial begin
    @(posedge clock);
    #2;
    // Reset values
    checkOutput("reset busy",       32'(busy),       32'd0);
    checkOutput("reset mem_addr",   32'(mem_addr),   32'd0);
    checkOutput("reset clip_valid", 32'(clip_valid), 32'd0);
    checkOutput("reset done",       32'(done),       32'd0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Full recording into slot 1, one idle cycle between ticks
    clearLogs();
    applyStimulus(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < CLIP_SAMPLES; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rec1 we count", 32'(we_log.size()), 32'd8);
    for (int i = 0; i < we_log.size(); i++) checkOutput("rec1 we addr", 32'(we_log[i]), 32'(i));
    checkOutput("rec1 done pulses", 32'(done_cnt), 32'd1);
    checkOutput("rec1 clip_valid", 32'(clip_valid), 32'b10);

    // Play request on an empty slot is rejected
    clearLogs();
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rej err pulses", 32'(err_cnt), 32'd1);
    checkOutput("rej busy", 32'(busy), 32'd0);
    checkOutput("rej seri_ena", 32'(seri_ena), 32'd0);

    // Complete slot 0, then overwrite it and abort after 3 ticks
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < CLIP_SAMPLES; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rec0 clip_valid", 32'(clip_valid), 32'b11);
    clearLogs();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("overwrite invalidates", 32'(clip_valid), 32'b10);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort addr held", 32'(mem_addr), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("abort done pulses", 32'(done_cnt), 32'd0);
    checkOutput("abort clip_valid", 32'(clip_valid), 32'b10);

    // Both requests high: record wins; then stop together with the final tick
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("prio deseri_ena", 32'(deseri_ena), 32'd1);
    checkOutput("prio seri_ena", 32'(seri_ena), 32'd0);
    clearLogs();
    for (int i = 0; i < CLIP_SAMPLES - 1; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("recstop done pulses", 32'(done_cnt), 32'd0);
    checkOutput("recstop clip_valid", 32'(clip_valid), 32'b10);

    // Play slot 1 with stop on the 8th tick
    clearLogs();
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("play seri_ena", 32'(seri_ena), 32'd1);
    for (int i = 0; i < CLIP_SAMPLES - 1; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("playstop done pulses", 32'(done_cnt), 32'd0);
    checkOutput("playstop addr held", 32'(mem_addr), 32'd7);
    checkOutput("playstop clip_valid", 32'(clip_valid), 32'b10);

    // Playback of slot 1 with loop=1 for 20 ticks
    clearLogs();
    applyStimulus(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    if (LOOP_BUILD) begin
      checkOutput("loop tick count", 32'(play_log.size()), 32'd20);
      for (int i = 0; i < play_log.size(); i++)
        checkOutput("loop addr", 32'(play_log[i]), 32'(i % 8));
      checkOutput("loop done pulses", 32'(done_cnt), 32'd2);
    end else begin
      checkOutput("noloop tick count", 32'(play_log.size()), 32'd8);
      for (int i = 0; i < play_log.size(); i++)
        checkOutput("noloop addr", 32'(play_log[i]), 32'(i));
      checkOutput("noloop done pulses", 32'(done_cnt), 32'd1);
    end
    checkOutput("final busy", 32'(busy), 32'd0);
    checkOutput("final clip_valid", 32'(clip_valid), 32'b10);

    // Reset mid-recording loses all valid bits
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset clip_valid", 32'(clip_valid), 32'd0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
